// File: rtl/la_cap_pkg.sv
// Shared types and defaults for the logic-analyzer capture controller.
// Provides the controller state encoding, default widths, and the
// capture-length clamp used when the controller is armed.
package la_cap_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // A zero or oversized request means "fill the whole buffer".
  function automatic int unsigned clamp_len(input int unsigned req,
                                            input int unsigned depth);
    return ((req == 0) || (req > depth)) ? depth : req;
  endfunction

endpackage

// File: rtl/la_cap_fifo.sv
// Capture buffer: DEPTH x DATA_W register array with first-word-fall-through
// read, synchronous flush and occupancy count.
// Ports:
//   clk, resetn  - clock, async active-low reset
//   flush_i      - empty the buffer (wins over write/read)
//   wr_en_i      - write wr_data_i at the tail
//   rd_en_i      - pop the head (ignored when empty)
//   rd_data_o    - head entry, zero while empty
//   count_o      - entries held
module la_cap_fifo
  import la_cap_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned CNT_W  = $clog2(DEPTH_DEF) + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_fire;
  logic              rd_fire;

  assign wr_fire = wr_en_i && !flush_i;
  assign rd_fire = rd_en_i && !flush_i && (count_q != '0);

  // Pointer/count next state; pointers wrap naturally (DEPTH is a power of two).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_fire, rd_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/count registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only observable through a non-zero count.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o   = count_q;

endmodule

// File: rtl/la_capture_ctrl.sv
// Logic-analyzer trigger/capture sequencer. Waits for a masked match on the
// probe slice, records a programmed number of consecutive samples, then
// presents them on a valid/ready read port for firmware to drain.
// Ports:
//   clk, resetn                   - clock, async active-low reset
//   cfg_arm, cfg_abort            - control pulses
//   trig_value, trig_mask         - trigger pattern and participating bits
//   capture_len                   - samples to record, sampled on arm
//   la_data                       - probe slice
//   rd_valid, rd_ready, rd_data   - FWFT read port (active in DONE)
//   busy, done, triggered, count  - status
module la_capture_ctrl
  import la_cap_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned CNT_W  = $clog2(DEPTH_DEF) + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cfg_arm,
  input  logic              cfg_abort,
  input  logic [DATA_W-1:0] trig_value,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [CNT_W-1:0]  capture_len,
  input  logic [DATA_W-1:0] la_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              triggered,
  output logic [CNT_W-1:0]  count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             trig_q, trig_d;
  logic             fifo_flush;
  logic             fifo_wr;
  logic             fifo_rd;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] len_req;
  logic             match;

  assign match   = ((la_data ^ trig_value) & trig_mask) == '0;
  assign len_req = CNT_W'(clamp_len(32'(capture_len), DEPTH));

  // Next-state, buffer control and sticky trigger; abort overrides everything.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    trig_d     = trig_q;
    fifo_flush = 1'b0;
    fifo_wr    = 1'b0;
    fifo_rd    = 1'b0;
    if (cfg_abort) begin
      state_d    = ST_IDLE;
      fifo_flush = 1'b1;
      trig_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          fifo_rd = rd_valid && rd_ready;
          if (cfg_arm) begin
            state_d    = ST_ARMED;
            fifo_flush = 1'b1;
            trig_d     = 1'b0;
            len_d      = len_req;
          end
        end
        ST_ARMED: begin
          if (match) begin
            fifo_wr = 1'b1;
            trig_d  = 1'b1;
            state_d = (len_q == CNT_W'(1)) ? ST_DONE : ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          fifo_wr = 1'b1;
          // This write brings the buffer up to the programmed length.
          if ((fifo_count + CNT_W'(1)) == len_q) state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, length and trigger-flag registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      trig_q  <= trig_d;
    end
  end

  la_cap_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .flush_i   (fifo_flush),
    .wr_en_i   (fifo_wr),
    .wr_data_i (la_data),
    .rd_en_i   (fifo_rd),
    .rd_data_o (rd_data),
    .count_o   (fifo_count)
  );

  // Status decodes straight from registered state and count.
  assign busy      = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
  assign done      = (state_q == ST_DONE);
  assign triggered = trig_q;
  assign count     = fifo_count;
  assign rd_valid  = done && (fifo_count != '0);

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Self-checking bench for la_capture_ctrl: directed captures with a
// scoreboard of expected read words, plus status checks at key cycles.
module tb_la_capture_ctrl;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CNT_W  = 5;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              cfg_arm = 1'b0;
  logic              cfg_abort = 1'b0;
  logic [DATA_W-1:0] trig_value = '0;
  logic [DATA_W-1:0] trig_mask = '0;
  logic [CNT_W-1:0]  capture_len = '0;
  logic [DATA_W-1:0] la_data = '0;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              triggered;
  logic [CNT_W-1:0]  count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  la_capture_ctrl #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cfg_arm     (cfg_arm),
    .cfg_abort   (cfg_abort),
    .trig_value  (trig_value),
    .trig_mask   (trig_mask),
    .capture_len (capture_len),
    .la_data     (la_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .busy        (busy),
    .done        (done),
    .triggered   (triggered),
    .count       (count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every accepted read word must match the queue head.
  always @(negedge clk) begin
    if (resetn && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_pop got=%h exp=<none> t=%0t", rd_data, $time);
      end else begin
        chk("sb_rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  task automatic arm(input logic [CNT_W-1:0] len, input logic [31:0] val,
                     input logic [31:0] mask, input logic [31:0] start);
    @(posedge clk); #1;
    trig_value  = val;
    trig_mask   = mask;
    capture_len = len;
    cfg_arm     = 1'b1;
    @(posedge clk); #1;
    cfg_arm = 1'b0;
    la_data = start;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      la_data = la_data + 32'd1;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    rd_ready = 1'b1;
    while (count != '0 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_in_time", 32'(k < 40), 32'd1);
    rd_ready = 1'b0;
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset values, during and after reset
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_trig", 32'(triggered), 32'd0);
    chk("idle_count", 32'(count), 32'd0);
    chk("idle_rd_data", rd_data, 32'd0);

    // 2. masked trigger, len 4
    arm(5'd4, 32'hAB40_0000, 32'hFFFF_0000, 32'hAB3F_FFFC);
    @(negedge clk);
    chk("t2_busy_armed", 32'(busy), 32'd1);
    chk("t2_no_trig_yet", 32'(triggered), 32'd0);
    step(7);
    @(negedge clk);
    chk("t2_count3", 32'(count), 32'd3);
    chk("t2_not_done", 32'(done), 32'd0);
    chk("t2_triggered", 32'(triggered), 32'd1);
    step(1);
    @(negedge clk);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_busy_low", 32'(busy), 32'd0);
    chk("t2_count4", 32'(count), 32'd4);
    chk("t2_rd_valid", 32'(rd_valid), 32'd1);
    exp_q.push_back(32'hAB40_0000);
    exp_q.push_back(32'hAB40_0001);
    exp_q.push_back(32'hAB40_0002);
    exp_q.push_back(32'hAB40_0003);
    drain();
    @(negedge clk);
    chk("t2_rd_valid_end", 32'(rd_valid), 32'd0);
    chk("t2_done_hold", 32'(done), 32'd1);

    // 3. length clamp: 0 and 20 both capture 16
    arm(5'd0, 32'h0, 32'h0, 32'h1000_0000);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h1000_0000 + 32'(i));
    step(15);
    @(negedge clk);
    chk("t3a_count15", 32'(count), 32'd15);
    chk("t3a_not_done", 32'(done), 32'd0);
    step(1);
    @(negedge clk);
    chk("t3a_count16", 32'(count), 32'd16);
    chk("t3a_done", 32'(done), 32'd1);
    drain();
    arm(5'd20, 32'h0, 32'h0, 32'h2000_0100);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h2000_0100 + 32'(i));
    step(16);
    @(negedge clk);
    chk("t3b_count16", 32'(count), 32'd16);
    chk("t3b_done", 32'(done), 32'd1);
    drain();

    // 4. abort on the third capture cycle; rd_ready held high throughout
    rd_ready = 1'b1;
    arm(5'd8, 32'h0, 32'h0, 32'h3000_0000);
    step(3);
    cfg_abort = 1'b1;
    @(negedge clk);
    chk("t4_count3", 32'(count), 32'd3);
    chk("t4_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    cfg_abort = 1'b0;
    @(negedge clk);
    chk("t4_abort_busy", 32'(busy), 32'd0);
    chk("t4_abort_done", 32'(done), 32'd0);
    chk("t4_abort_count", 32'(count), 32'd0);
    chk("t4_abort_trig", 32'(triggered), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t4_no_rd_valid", 32'(rd_valid), 32'd0);
      @(negedge clk);
    end
    rd_ready = 1'b0;
    @(posedge clk); #1;
    cfg_arm = 1'b1;
    cfg_abort = 1'b1;
    @(posedge clk); #1;
    cfg_arm = 1'b0;
    cfg_abort = 1'b0;
    @(negedge clk);
    chk("t4_arm_abort_busy", 32'(busy), 32'd0);
    chk("t4_arm_abort_done", 32'(done), 32'd0);

    // 5. read backpressure after a 6-word capture
    arm(5'd6, 32'h0, 32'h0, 32'h4000_0000);
    for (int i = 0; i < 6; i++) exp_q.push_back(32'h4000_0000 + 32'(i));
    step(6);
    for (int i = 0; i < 12; i++) begin
      rd_ready = (i % 2 == 0);
      @(negedge clk);
      if (i == 0) chk("t5_done", 32'(done), 32'd1);
      chk("t5_count_step", 32'(count), 32'(6 - (i + 1) / 2));
      @(posedge clk); #1;
    end
    rd_ready = 1'b0;
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("t5_rd_valid_end", 32'(rd_valid), 32'd0);
    arm(5'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    @(negedge clk);
    chk("t5_rearm_done", 32'(done), 32'd0);
    chk("t5_rearm_busy", 32'(busy), 32'd1);
    chk("t5_rearm_trig", 32'(triggered), 32'd0);
    @(posedge clk); #1 cfg_abort = 1'b1;
    @(posedge clk); #1 cfg_abort = 1'b0;
    @(negedge clk);
    chk("t5_abort_busy", 32'(busy), 32'd0);

    // 6. async reset mid-capture, then a fresh capture
    arm(5'd8, 32'h0, 32'h0, 32'h5000_0000);
    step(3);
    #2 resetn = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_trig", 32'(triggered), 32'd0);
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("t6_rst_rd_data", rd_data, 32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    arm(5'd2, 32'h0, 32'h0, 32'h6000_0000);
    exp_q.push_back(32'h6000_0000);
    exp_q.push_back(32'h6000_0001);
    step(2);
    @(negedge clk);
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_count2", 32'(count), 32'd2);
    drain();

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/la_capture_ctrl.md
Name: la_capture_ctrl

Overview:
- Trigger/capture sequencer for the 128-bit logic-analyzer path between the management core and the user project.
- Watches a 32-bit LA probe slice for a masked trigger pattern, then records a programmed number of consecutive samples into a small buffer.
- Management firmware drains the buffer through a valid/ready read port.
- Sits in the user project next to the LA interface. Firmware arms it and reads it back, then reports results on the checkpoint GPIOs.

Parameters:
- DATA_W, 32, width of the sampled LA slice.
- DEPTH, 16, capture buffer entries (power of two, ≥2).
- CNT_W, 5, width of length/count fields (= log2(DEPTH)+1).

Ports:
- clk  in  1  sole clock, the user-project/Wishbone clock.
- resetn  in  1  asynchronous, active-low reset.
- cfg_arm  in  1  single-cycle pulse: clear buffer, enter ARMED.
- cfg_abort  in  1  single-cycle pulse: return to IDLE, clear buffer.
- trig_value  in  DATA_W  trigger compare value.
- trig_mask  in  DATA_W  1 = bit participates in the compare.
- capture_len  in  CNT_W  samples to record; sampled on arm.
- la_data  in  DATA_W  probe data, already synchronous to clk.
- rd_valid  out  1  buffer word available (DONE only).
- rd_ready  in  1  consumer accepts rd_data.
- rd_data  out  DATA_W  oldest buffered sample (first-word-fall-through).
- busy  out  1  state is ARMED or CAPTURE.
- done  out  1  state is DONE.
- triggered  out  1  sticky; set on trigger match, cleared by arm/abort.
- count  out  CNT_W  words currently held in the buffer.

Behaviour:
- Reset:
  - State IDLE; pointers and count 0; internal length register 0.
  - busy=0, done=0, triggered=0, rd_valid=0, count=0.
  - rd_data=0 while the buffer is empty.
- States: IDLE, ARMED, CAPTURE, DONE (2-bit encoding).
- IDLE/DONE + cfg_arm:
  - Go to ARMED next cycle; clear buffer and triggered.
  - Latch len = (capture_len==0 || capture_len>DEPTH) ? DEPTH : capture_len.
- cfg_arm in ARMED or CAPTURE: ignored.
- cfg_abort in any state: go to IDLE next cycle; clear buffer and triggered.
  - Abort wins over a simultaneous arm, trigger or read.
- ARMED, trigger check: match = (((la_data ^ trig_value) & trig_mask) == 0).
  - On match, la_data of that same cycle is written as entry 0 and triggered is set.
  - If len==1, go to DONE; otherwise go to CAPTURE.
  - trig_mask==0 matches on the first ARMED cycle.
- CAPTURE: write la_data every cycle (no gaps). When the write makes count==len, go to DONE the following cycle.
- done first rises the cycle after the final sample is written.
- Total write latency: trigger cycle + len-1 cycles.
- Buffer full: by construction len≤DEPTH, so no overflow. Writes outside ARMED/CAPTURE are impossible.
- Read port:
  - rd_valid = (state==DONE) && count!=0.
  - Pop on rd_valid && rd_ready; count decrements.
  - rd_ready with rd_valid=0 has no effect.
- DONE with count==0: stays in DONE (done=1) until arm or abort.
- Pointers wrap modulo DEPTH. count saturates at neither end; the design prevents both underflow and overflow.
- Async reset mid-capture: everything returns to reset values immediately; no partial data is visible.

Decomposition:
- Shared package la_cap_pkg:
  - state enum {IDLE, ARMED, CAPTURE, DONE}.
  - DATA_W/DEPTH defaults.
  - Helper constant for clamp of capture_len.
- Sub-module la_cap_fifo:
  - DEPTH×DATA_W register array with write port, FWFT read port, flush input and count.
  - Same clk/resetn.
- The controller FSM and trigger compare stay in la_capture_ctrl.

Test Plan:
1. Reset values: hold resetn=0 → busy=0, done=0, rd_valid=0, count=0. Release, idle 20 cycles → unchanged.
2. Masked trigger:
   - Stimulus: trig_value=32'hAB40_0000, trig_mask=32'hFFFF_0000, capture_len=4; la_data counter starting 32'hAB3F_FFFC, increment 1/cycle.
   - Response: trigger on 32'hAB40_0000; buffer holds AB40_0000..AB40_0003; done one cycle after the 4th write.
   - Readout with rd_ready=1 yields those 4 words, then rd_valid=0.
3. Length clamp: capture_len=0, then capture_len=20, each with trig_mask=0 → 16 words captured each time; count=16, done=1.
4. Abort mid-capture: len=8, assert cfg_abort on the 3rd capture cycle → IDLE next cycle; count=0, triggered=0, rd_valid never rises. Also assert cfg_arm and cfg_abort together → IDLE.
5. Read backpressure: after a 6-word capture, toggle rd_ready 1/0 every cycle → words are delivered in order with none lost or duplicated; count steps 6→0. A re-arm afterwards clears done.
6. Async reset mid-capture: pull resetn low off-edge during CAPTURE → all outputs go to reset values immediately. A fresh arm afterwards captures correctly.
